// File: rtl/i2c_reg_xfer.sv
// rtl/i2c_reg_xfer.sv - register-level I2C write/read sequencer with NACK abort and retry
module i2c_reg_xfer #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_BYTES = 1,
  parameter int MAX_DATA_BYTES = 4,
  parameter int RETRY_MAX      = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_rnw_i,
  input  logic [6:0]                    req_dev_addr_i,
  input  logic [8*REG_ADDR_BYTES-1:0]   req_reg_addr_i,
  input  logic [$clog2(MAX_DATA_BYTES+1)-1:0] req_len_i,
  input  logic [8*MAX_DATA_BYTES-1:0]   req_wdata_i,
  output logic                          done_o,
  output logic                          err_o,
  output logic [8*MAX_DATA_BYTES-1:0]   rdata_o,
  output logic                          start_o,
  output logic                          stop_o,
  output logic                          read_o,
  output logic                          write_o,
  output logic                          ack_in_o,
  output logic [DATA_WIDTH-1:0]         din_o,
  input  logic [DATA_WIDTH-1:0]         dout_i,
  input  logic                          cmd_ack_i,
  input  logic                          ack_out_i
);
  localparam int LW   = $clog2(MAX_DATA_BYTES + 1);
  localparam int IMAX = (REG_ADDR_BYTES > MAX_DATA_BYTES) ? REG_ADDR_BYTES : MAX_DATA_BYTES;
  localparam int IW   = $clog2(IMAX + 1);
  localparam int RW   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_DATA_BYTES);
  localparam logic [IW-1:0] REG_LAST  = IW'(REG_ADDR_BYTES - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_W, S_REG, S_DATA_W, S_DEV_R, S_DATA_R, S_ABORT, S_DONE, S_ERR
  } state_t;

  state_t state, state_nx, retry_nx;

  logic                        rnw_q;
  logic [6:0]                  dev_q;
  logic [8*REG_ADDR_BYTES-1:0] reg_q;
  logic [LW-1:0]               len_q;
  logic [8*MAX_DATA_BYTES-1:0] wdata_q;
  logic [8*MAX_DATA_BYTES-1:0] rdata_q;
  logic [IW-1:0]               idx_q;
  logic [RW-1:0]               retry_q;
  logic                        gap_q;

  logic [LW-1:0] len_clamped;
  logic [IW-1:0] len_m1;
  logic          accept, cmd_state, cmd_active, cmd_done, nack;
  logic          reg_last, data_last, retry_ok;

  assign len_clamped = (req_len_i > MAX_LEN) ? MAX_LEN : req_len_i;
  assign req_ready_o = (state == S_IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign cmd_state   = state inside {S_DEV_W, S_REG, S_DATA_W, S_DEV_R, S_DATA_R, S_ABORT};
  // gap_q forces one idle cycle between consecutive commands
  assign cmd_active  = cmd_state && !gap_q;
  assign cmd_done    = cmd_active && cmd_ack_i;
  assign nack        = ack_out_i && write_o;
  assign len_m1      = IW'(len_q) - IW'(1);
  assign reg_last    = (idx_q == REG_LAST);
  assign data_last   = (idx_q == len_m1);
  assign retry_ok    = (retry_q < RETRY_LIM);
  assign retry_nx    = retry_ok ? S_DEV_W : S_ERR;
  assign rdata_o     = rdata_q;

  // State register; reset abandons any transaction without a stop
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state: advance on each acknowledged command, divert to abort/retry on NACK
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = (req_rnw_i && len_clamped == '0) ? S_ERR : S_DEV_W;
      S_DEV_W:  if (cmd_done) state_nx = nack ? S_ABORT : S_REG;
      S_REG: begin
        if (cmd_done) begin
          if (nack)          state_nx = stop_o ? retry_nx : S_ABORT;
          else if (reg_last) state_nx = rnw_q ? S_DEV_R : ((len_q == '0) ? S_DONE : S_DATA_W);
        end
      end
      S_DATA_W: begin
        if (cmd_done) begin
          if (nack)           state_nx = stop_o ? retry_nx : S_ABORT;
          else if (data_last) state_nx = S_DONE;
        end
      end
      S_DEV_R:  if (cmd_done) state_nx = nack ? S_ABORT : S_DATA_R;
      S_DATA_R: if (cmd_done && data_last) state_nx = S_DONE;
      S_ABORT:  if (cmd_done) state_nx = retry_nx;
      S_DONE:   state_nx = S_IDLE;
      S_ERR:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Request latch, byte index, retry count and read-data capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rnw_q   <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      gap_q   <= 1'b0;
    end else begin
      gap_q <= cmd_done;
      if (accept) begin
        rnw_q   <= req_rnw_i;
        dev_q   <= req_dev_addr_i;
        reg_q   <= req_reg_addr_i;
        len_q   <= len_clamped;
        wdata_q <= req_wdata_i;
        idx_q   <= '0;
        retry_q <= '0;
        if (req_rnw_i) begin
          for (int k = 0; k < MAX_DATA_BYTES; k++) begin
            if (LW'(k) >= len_clamped) rdata_q[k*8 +: 8] <= 8'h00;
          end
        end
      end
      if (cmd_done) begin
        idx_q <= (state_nx == state) ? idx_q + IW'(1) : '0;
        if (state_nx == S_DEV_W) retry_q <= retry_q + RW'(1);
        if (state == S_DATA_R) rdata_q[int'(idx_q)*8 +: 8] <= dout_i[7:0];
      end
    end
  end

  // Command outputs decoded from state; all low during the inter-command gap
  always_comb begin
    start_o  = 1'b0;
    stop_o   = 1'b0;
    read_o   = 1'b0;
    write_o  = 1'b0;
    ack_in_o = 1'b0;
    din_o    = '0;
    done_o   = 1'b0;
    err_o    = 1'b0;
    case (state)
      S_DEV_W: if (!gap_q) begin
        start_o = 1'b1;
        write_o = 1'b1;
        din_o   = DATA_WIDTH'({dev_q, 1'b0});
      end
      S_REG: if (!gap_q) begin
        write_o = 1'b1;
        stop_o  = reg_last && !rnw_q && (len_q == '0);
        din_o   = DATA_WIDTH'(reg_q[(REG_ADDR_BYTES-1-int'(idx_q))*8 +: 8]);
      end
      S_DATA_W: if (!gap_q) begin
        write_o = 1'b1;
        stop_o  = data_last;
        din_o   = DATA_WIDTH'(wdata_q[int'(idx_q)*8 +: 8]);
      end
      S_DEV_R: if (!gap_q) begin
        start_o = 1'b1;
        write_o = 1'b1;
        din_o   = DATA_WIDTH'({dev_q, 1'b1});
      end
      S_DATA_R: if (!gap_q) begin
        read_o   = 1'b1;
        ack_in_o = data_last;
        stop_o   = data_last;
      end
      S_ABORT: if (!gap_q) stop_o = 1'b1;
      S_DONE: done_o = 1'b1;
      S_ERR: begin
        done_o = 1'b1;
        err_o  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
